bus_slave_port: RTL and testbench
=================================

// Module: bus_slave_port
// PURPOSE
//  Slave-side endpoint of the serial master/slave bus. Sits behind the arbiter on one slave slot
//  (s1/s2/s3). Deserialises address, write_en and write data from the arbiter's per-slave lines.
//  Performs the access on a local register memory. For reads, returns data serially with a
//  valid strobe. Drives ready, which the arbiter uses for connection and split decisions.
// PARAMETERS
//  ADDR_WIDTH    4   serial address bits per transaction; memory depth = 2**ADDR_WIDTH
//  DATA_WIDTH    8   serial data bits per transaction (write and read)
//  READ_LATENCY  2   cycles in RWAIT between last address bit and first read bit; legal >=1
//  TIMEOUT       16  consecutive valid_in=0 cycles in ADDR/WDATA before abort; legal >=1
// PORTS
//  clk          in   1  clock; all logic on posedge
//  reset        in   1  reset, synchronous, active-high
//  address_in   in   1  serial address bit, MSB first (arbiter sN_address)
//  data_in      in   1  serial write-data bit, MSB first (arbiter sN_data)
//  valid_in     in   1  qualifies address_in/data_in this cycle (arbiter sN_valid)
//  write_en_in  in   1  1=write, 0=read; sampled on first accepted bit only (sN_write_en)
//  ready        out  1  1 only when idle and able to start a transaction (to sN_ready)
//  data_out     out  1  serial read-data bit, MSB first (to sN_data_in)
//  valid_out    out  1  qualifies data_out (to sN_valid_out)
// BEHAVIOUR
//  Reset values: state=IDLE, ready=1, data_out=0, valid_out=0, counters=0.
//  Memory contents are not reset. Reset has priority in every state, including mid-transaction;
//  an interrupted write does not update memory.
//  ready = (state==IDLE), decoded from the state register. data_out/valid_out are registered.
//  States and transitions:
//  - IDLE: valid_in=1 captures address_in as addr[MSB] and latches write_en_in.
//    Goes to ADDR with bit_cnt=1. valid_in=0 stays in IDLE.
//  - ADDR: each valid_in=1 cycle shifts in one address bit; valid_in=0 holds (stall, no shift).
//    After bit ADDR_WIDTH: write -> WDATA, read -> RWAIT.
//  - WDATA: each valid_in=1 cycle shifts in one data_in bit; stalls as in ADDR.
//    After bit DATA_WIDTH -> WRITE.
//  - WRITE: single cycle; mem[addr] <= wdata; -> IDLE.
//  - RWAIT: READ_LATENCY cycles; the shift register loads mem[addr] in the last cycle; -> RDATA.
//  - RDATA: exactly DATA_WIDTH consecutive cycles with valid_out=1 and data_out=current MSB,
//    left shift each cycle. After the last bit -> IDLE; valid_out=0 in the IDLE cycle.
//  - If ADDR_WIDTH==1, the IDLE capture completes the address: go directly to WDATA/RWAIT.
//  valid_in, address_in and data_in are ignored in WRITE, RWAIT and RDATA.
//  write_en_in is ignored after the first bit.
//  Timeout: idle_cnt counts consecutive valid_in=0 cycles in ADDR/WDATA; any valid_in=1 clears it.
//  When idle_cnt reaches TIMEOUT: -> IDLE, no memory write, partial shift data discarded.
//  Latency: a write is TA=ADDR_WIDTH+DATA_WIDTH accepted bits, then 1 WRITE cycle, then IDLE.
//  Latency: a read gives its first valid_out READ_LATENCY+1 cycles after the last address bit.
//  Back-to-back: valid_in=1 in the first IDLE cycle (ready=1) starts the next transaction.
//  Address is unsigned ADDR_WIDTH bits and indexes memory directly; there is no wrap or
//  out-of-range case. bit_cnt width = clog2(max(ADDR_WIDTH,DATA_WIDTH)+1).
// TESTING  (ADDR_WIDTH=4, DATA_WIDTH=8, READ_LATENCY=2, TIMEOUT=16)
//  1 Write 4'hA/8'hA5: 12 contiguous valid bits, we=1 -> ready=0 from the cycle after bit 1
//    to the WRITE cycle; ready=1 next; mem[10]==8'hA5.
//  2 Read 4'hA after test 1: 4 address bits, we=0 -> 2 RWAIT cycles, then valid_out=1 for 8 cycles
//    with data_out=1,0,1,0,0,1,0,1; then valid_out=0, ready=1.
//  3 Write 4'h3/8'h3C with 3-cycle valid_in=0 gaps after address bit 2 and data bit 5 -> no
//    timeout; readback of 4'h3 gives 8'h3C.
//  4 Write 4'h5 with data 8'hFF, stopping after 2 data bits for 16 cycles -> IDLE and ready=1
//    on timeout; mem[5] unchanged.
//  5 Reset asserted in RDATA cycle 3 -> next cycle valid_out=0, data_out=0, ready=1; a new read
//    then completes correctly.
//  6 Write 4'h1/8'h81, then valid_in=1 in the first cycle ready=1 starts a read of 4'h1 -> returns
//    8'h81 with no bits dropped.

Source files
------------

// File: rtl/bus_slave_port.sv
// Slave-side endpoint of the serial master/slave bus.
// Deserialises address, write_en and write data from the arbiter's per-slave
// lines, performs the access on a local register memory and returns read data
// serially, MSB first, qualified by valid_out. ready is high only in IDLE.
module bus_slave_port #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int TIMEOUT      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic address_in,
  input  logic data_in,
  input  logic valid_in,
  input  logic write_en_in,
  output logic ready,
  output logic data_out,
  output logic valid_out
);

  localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  // Counter values that mark the final bit / cycle of each phase.
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam bit                ADDR_ONE  = (ADDR_WIDTH == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RWAIT,
    S_RDATA
  } state_t;

  // Control state (reset).
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  // Datapath state (not reset).
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;
  logic [DATA_WIDTH-1:0] rdata_shift;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Serial shift helpers: new bits enter at the LSB so the first bit ends up
  // in the MSB once the field is complete; the cast drops the bit shifted out.
  assign addr_shift  = ADDR_WIDTH'({addr_q, address_in});
  assign wdata_shift = DATA_WIDTH'({wdata_q, data_in});
  assign rdata_shift = rdata_q << 1;
  assign mem_rd      = mem_q[addr_q];

  assign ready     = (state_q == S_IDLE);
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

  // Next-state and output decode for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    data_out_d  = 1'b0;
    valid_out_d = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          addr_d     = addr_shift;
          we_d       = write_en_in;
          idle_cnt_d = '0;
          if (ADDR_ONE) begin
            // A one-bit address is complete on the capture cycle itself.
            bit_cnt_d = '0;
            lat_cnt_d = '0;
            state_d   = write_en_in ? S_WDATA : S_RWAIT;
          end else begin
            bit_cnt_d = CNT_W'(1);
            state_d   = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (valid_in) begin
          addr_d     = addr_shift;
          idle_cnt_d = '0;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            lat_cnt_d = '0;
            state_d   = we_q ? S_WDATA : S_RWAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          // Master went silent: abandon the partial transaction.
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      S_WDATA: begin
        if (valid_in) begin
          wdata_d    = wdata_shift;
          idle_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          // Partial write data is discarded; memory is left untouched.
          state_d    = S_IDLE;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      S_WRITE: begin
        mem_we    = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end

      S_RWAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          // Load the word and present its MSB on the first RDATA cycle.
          rdata_d     = mem_rd;
          data_out_d  = mem_rd[DATA_WIDTH-1];
          valid_out_d = 1'b1;
          bit_cnt_d   = '0;
          lat_cnt_d   = '0;
          state_d     = S_RDATA;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      S_RDATA: begin
        if (bit_cnt_q == DATA_LAST) begin
          // Last bit is on the wire now; outputs drop as IDLE begins.
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          bit_cnt_d   = bit_cnt_q + 1'b1;
          rdata_d     = rdata_shift;
          data_out_d  = rdata_shift[DATA_WIDTH-1];
          valid_out_d = 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Control registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Address, write-data and read-data shift registers.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // Register memory; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed testbench for bus_slave_port (ADDR_WIDTH=4, DATA_WIDTH=8,
// READ_LATENCY=2, TIMEOUT=16).
module tb_bus_slave_port;

  logic clk;
  logic reset;
  logic address_in;
  logic data_in;
  logic valid_in;
  logic write_en_in;
  logic ready;
  logic data_out;
  logic valid_out;

  int n_checks;
  int n_fail;

  bus_slave_port #(
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (8),
    .READ_LATENCY(2),
    .TIMEOUT     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address_in (address_in),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .write_en_in(write_en_in),
    .ready      (ready),
    .data_out   (data_out),
    .valid_out  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial write; g1/g2 insert glen idle cycles after that 1-based bit number.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                          input int g1, input int g2, input int glen, input string tag);
    logic [11:0] bits;
    bits = {a, d};
    for (int i = 0; i < 12; i++) begin
      valid_in    = 1'b1;
      address_in  = (i < 4)  ? bits[11-i] : 1'b0;
      data_in     = (i >= 4) ? bits[11-i] : 1'b0;
      write_en_in = (i == 0);
      step();
      if (i == 0) chk({tag, "_ready_after_bit1"}, ready, 1'b0);
      if ((i + 1 == g1) || (i + 1 == g2)) begin
        valid_in   = 1'b0;
        address_in = 1'b1;
        data_in    = 1'b1;
        for (int j = 0; j < glen; j++) step();
        chk({tag, "_ready_in_gap"}, ready, 1'b0);
      end
    end
    valid_in    = 1'b0;
    write_en_in = 1'b0;
    address_in  = 1'b0;
    data_in     = 1'b0;
    chk({tag, "_ready_write_cycle"}, ready, 1'b0);
    step();
    chk({tag, "_ready_after_write"}, ready, 1'b1);
  endtask

  // Serial read with latency and framing checks; ends in the IDLE cycle.
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 0; i < 4; i++) begin
      valid_in    = 1'b1;
      address_in  = a[3-i];
      data_in     = 1'b1;
      write_en_in = 1'b0;
      step();
    end
    valid_in   = 1'b0;
    address_in = 1'b0;
    data_in    = 1'b0;
    chk({tag, "_vout_rwait1"}, valid_out, 1'b0);
    step();
    chk({tag, "_vout_rwait2"}, valid_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk({tag, "_vout_rdata"}, valid_out, 1'b1);
      got = {got[6:0], data_out};
    end
    step();
    chk({tag, "_vout_end"}, valid_out, 1'b0);
    chk({tag, "_ready_end"}, ready, 1'b1);
    chk({tag, "_rdata"}, got, exp);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    address_in  = 1'b0;
    data_in     = 1'b0;
    valid_in    = 1'b0;
    write_en_in = 1'b0;

    // Reset state
    step();
    step();
    step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 1'b0);
    reset = 1'b0;
    step();

    // 1: contiguous write A <- A5
    do_write(4'hA, 8'hA5, 0, 0, 0, "t1");
    step();

    // 2: read A back (1,0,1,0,0,1,0,1)
    do_read(4'hA, 8'hA5, "t2");
    step();

    // 3: write with stall gaps below the timeout, then read back
    do_write(4'h3, 8'h3C, 2, 9, 3, "t3");
    step();
    do_read(4'h3, 8'h3C, "t3r");
    step();

    // 4: timeout in WDATA leaves memory unchanged
    do_write(4'h5, 8'h5A, 0, 0, 0, "t4pre");
    step();
    for (int i = 0; i < 6; i++) begin
      valid_in    = 1'b1;
      address_in  = (i < 4) ? (4'h5 >> (3 - i)) & 1'b1 : 1'b0;
      data_in     = 1'b1;
      write_en_in = (i == 0);
      step();
    end
    valid_in    = 1'b0;
    write_en_in = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("t4_ready_before_timeout", ready, 1'b0);
    step();
    chk("t4_ready_on_timeout", ready, 1'b1);
    step();
    do_read(4'h5, 8'h5A, "t4r");
    step();

    // 5: reset during RDATA cycle 3, then a clean read
    do_write(4'hC, 8'hFF, 0, 0, 0, "t5pre");
    step();
    for (int i = 0; i < 4; i++) begin
      valid_in    = 1'b1;
      address_in  = 1'b1 & (4'hC >> (3 - i));
      write_en_in = 1'b0;
      step();
    end
    valid_in   = 1'b0;
    address_in = 1'b0;
    step();
    step();
    chk("t5_rdata_c1", valid_out, 1'b1);
    step();
    step();
    chk("t5_rdata_c3_vout", valid_out, 1'b1);
    chk("t5_rdata_c3_dout", data_out, 1'b1);
    reset = 1'b1;
    step();
    chk("t5_rst_vout", valid_out, 1'b0);
    chk("t5_rst_dout", data_out, 1'b0);
    chk("t5_rst_ready", ready, 1'b1);
    reset = 1'b0;
    step();
    do_read(4'hC, 8'hFF, "t5r");
    step();

    // 6: write then back-to-back read in the first ready cycle
    do_write(4'h1, 8'h81, 0, 0, 0, "t6");
    do_read(4'h1, 8'h81, "t6r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
